// File: rtl/decodificador_rgb.sv
// decodificador_rgb: one-hot colour code to registered RGB LED pin levels.
// Rev 1.0 - initial release.
`default_nettype none

module decodificador_rgb #(
  parameter int LED_ATIVO_BAIXO = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] dados,
  output logic [2:0] leds_rgb
);

  localparam logic [2:0] C_COR_DESLIGADA = 3'b000;
  localparam logic [2:0] C_PINOS_OFF     = (LED_ATIVO_BAIXO != 0) ? 3'b111 : 3'b000;

  logic [2:0] cor;
  logic [2:0] pinos;

  // Logical colour {B,R,G}; anything that is not a single valid code is dark.
  always_comb begin
    cor = C_COR_DESLIGADA;
    if (en) begin
      case (dados)
        4'b0001: cor = 3'b010;
        4'b0010: cor = 3'b100;
        4'b0100: cor = 3'b011;
        4'b1000: cor = 3'b001;
        default: cor = C_COR_DESLIGADA;
      endcase
    end
  end

  assign pinos = (LED_ATIVO_BAIXO != 0) ? ~cor : cor;

  always_ff @(posedge clock) begin
    if (reset) begin
      leds_rgb <= C_PINOS_OFF;
    end else begin
      leds_rgb <= pinos;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decodificador_rgb.sv
// tb_decodificador_rgb: scoreboard bench for both LED polarities side by side.
`default_nettype none

module tb_decodificador_rgb;

  logic       clock;
  logic       reset;
  logic       en;
  logic [3:0] dados;
  logic [2:0] leds_h;
  logic [2:0] leds_l;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [2:0] h;
    logic [2:0] l;
    string      name;
  } exp_t;

  exp_t sb[$];

  decodificador_rgb #(.LED_ATIVO_BAIXO(0)) dut_h (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .dados    (dados),
    .leds_rgb (leds_h)
  );

  decodificador_rgb #(.LED_ATIVO_BAIXO(1)) dut_l (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .dados    (dados),
    .leds_rgb (leds_l)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: the output register updates every edge, so one entry is consumed per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, "_hi"}, leds_h, e.h);
        check({e.name, "_lo"}, leds_l, e.l);
      end
    end
  end

  logic [2:0] last_h;
  logic [2:0] last_l;
  bit         have_last = 0;

  // Drive on the falling edge; the outputs must not move until the next rising edge.
  task automatic step(input string name, input logic r, input logic e_in,
                      input logic [3:0] d, input logic [2:0] exp_h, input logic [2:0] exp_l);
    exp_t item;
    @(negedge clock);
    reset = r;
    en    = e_in;
    dados = d;
    item.h = exp_h;
    item.l = exp_l;
    item.name = name;
    sb.push_back(item);
    #1;
    if (have_last) begin
      check({name, "_hold_hi"}, leds_h, last_h);
      check({name, "_hold_lo"}, leds_l, last_l);
    end
    last_h = exp_h;
    last_l = exp_l;
    have_last = 1;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    dados = 4'b0001;

    step("rst1",       1, 0, 4'b0001, 3'b000, 3'b111);
    step("rst2",       1, 0, 4'b0001, 3'b000, 3'b111);
    step("rel_en0",    0, 0, 4'b0001, 3'b000, 3'b111);
    step("red",        0, 1, 4'b0001, 3'b010, 3'b101);
    step("blue",       0, 1, 4'b0010, 3'b100, 3'b011);
    step("yellow",     0, 1, 4'b0100, 3'b011, 3'b100);
    step("green",      0, 1, 4'b1000, 3'b001, 3'b110);
    step("multi_0011", 0, 1, 4'b0011, 3'b000, 3'b111);
    step("zero_0000",  0, 1, 4'b0000, 3'b000, 3'b111);
    step("all_1111",   0, 1, 4'b1111, 3'b000, 3'b111);
    step("green2",     0, 1, 4'b1000, 3'b001, 3'b110);
    step("en_drop",    0, 0, 4'b1000, 3'b000, 3'b111);
    step("en0_blue",   0, 0, 4'b0010, 3'b000, 3'b111);
    step("yellow2",    0, 1, 4'b0100, 3'b011, 3'b100);
    step("rst_lit",    1, 1, 4'b0100, 3'b000, 3'b111);
    step("resume",     0, 1, 4'b0100, 3'b011, 3'b100);
    step("red2",       0, 1, 4'b0001, 3'b010, 3'b101);
    step("multi_1010", 0, 1, 4'b1010, 3'b000, 3'b111);

    repeat (3) @(posedge clock);
    #2;
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
